fft_frame_assembler: RTL and testbench

//   Producer side of FFT_Top's packed frame input. Accepts a stream of signed audio

---
 rtl/fft_pkg.sv | 10 +
 rtl/fft_frame_bank.sv | 58 +++++
 rtl/fft_frame_assembler.sv | 86 ++++++++
 tb/tb_fft_frame_assembler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types: default sample/frame geometry used by the assembler and FFT_Top.
package fft_pkg;

  localparam int unsigned FFT_SAMPLE_W    = 32;
  localparam int unsigned FFT_BUFFER_SIZE = 32;

  typedef logic signed [FFT_SAMPLE_W-1:0]               sample_t;
  typedef logic        [FFT_BUFFER_SIZE*FFT_SAMPLE_W-1:0] frame_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One ping-pong bank: frame register, its write index and full flag.
module fft_frame_bank import fft_pkg::*; #(
  parameter  int unsigned SAMPLE_W    = FFT_SAMPLE_W,
  parameter  int unsigned BUFFER_SIZE = FFT_BUFFER_SIZE,
  localparam int unsigned IDX_W       = $clog2(BUFFER_SIZE),
  localparam int unsigned FRAME_W     = BUFFER_SIZE * SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                clr_idx,
  input  logic                consume,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [FRAME_W-1:0]  frame,
  output logic [IDX_W-1:0]    idx,
  output logic                full
);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               full_q, full_d;

  // A bank is never written and consumed in the same cycle: writes need !full, consume needs full.
  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    full_d  = full_q;
    if (consume) full_d = 1'b0;
    if (clr_idx) begin
      idx_d = '0;
    end else if (wr_en) begin
      frame_d[32'(idx_q) * SAMPLE_W +: SAMPLE_W] = sample;
      if (idx_q == IDX_W'(BUFFER_SIZE - 1)) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

  assign frame = frame_q;
  assign idx   = idx_q;
  assign full  = full_q;

endmodule

// File: rtl/fft_frame_assembler.sv
// Packs a valid/ready sample stream into BUFFER_SIZE-sample frames using two ping-pong banks.
module fft_frame_assembler import fft_pkg::*; #(
  parameter  int unsigned SAMPLE_W    = FFT_SAMPLE_W,
  parameter  int unsigned BUFFER_SIZE = FFT_BUFFER_SIZE,
  localparam int unsigned IDX_W       = $clog2(BUFFER_SIZE),
  localparam int unsigned FRAME_W     = BUFFER_SIZE * SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       flush,
  output logic [FRAME_W-1:0]         frame_out,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [IDX_W:0]             fill_level,
  output logic                       overrun
);

  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic overrun_q, overrun_d;

  logic [FRAME_W-1:0] bank_frame [2];
  logic [IDX_W-1:0]   bank_idx   [2];
  logic [1:0]         bank_full;
  logic [1:0]         bank_wr;
  logic [1:0]         bank_clr;
  logic [1:0]         bank_consume;

  logic accept;
  logic consume;
  logic complete;

  assign sample_ready = !bank_full[wr_bank_q] && !flush;
  assign frame_valid  = bank_full[rd_bank_q];
  assign frame_out    = bank_frame[rd_bank_q];
  assign overrun      = overrun_q;
  assign fill_level   = bank_full[wr_bank_q] ? (IDX_W+1)'(BUFFER_SIZE)
                                             : {1'b0, bank_idx[wr_bank_q]};

  assign accept   = sample_valid && sample_ready;
  assign consume  = frame_valid && frame_ready;
  assign complete = accept && (bank_idx[wr_bank_q] == IDX_W'(BUFFER_SIZE - 1));

  always_comb begin
    wr_bank_d = wr_bank_q ^ complete;
    rd_bank_d = rd_bank_q ^ consume;
    overrun_d = overrun_q | (sample_valid && !sample_ready && !flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr[b]      = accept  && (wr_bank_q == 1'(b));
    assign bank_clr[b]     = flush   && (wr_bank_q == 1'(b));
    assign bank_consume[b] = consume && (rd_bank_q == 1'(b));

    fft_frame_bank #(
      .SAMPLE_W    (SAMPLE_W),
      .BUFFER_SIZE (BUFFER_SIZE)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_wr[b]),
      .clr_idx (bank_clr[b]),
      .consume (bank_consume[b]),
      .sample  (sample_in),
      .frame   (bank_frame[b]),
      .idx     (bank_idx[b]),
      .full    (bank_full[b])
    );
  end

endmodule

// File: tb/tb_fft_frame_assembler.sv
// Directed bench for fft_frame_assembler: control table plus frame-level sequences.
module tb_fft_frame_assembler;
  import fft_pkg::*;

  localparam int unsigned SW = 32;
  localparam int unsigned BS = 32;

  logic              clk = 1'b0;
  logic              rst;
  sample_t           sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              flush;
  logic [BS*SW-1:0]  frame_out;
  logic              frame_valid;
  logic              frame_ready;
  logic [5:0]        fill_level;
  logic              overrun;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_s [BS];

  always #5 clk = ~clk;

  fft_frame_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .fill_level   (fill_level),
    .overrun      (overrun)
  );

  typedef struct {
    logic        sv;
    logic [31:0] s;
    logic        fl;
    logic        e_rdy;
    logic [5:0]  e_fill;
    logic        e_fv;
    logic        e_ovr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string name);
    for (int i = 0; i < int'(BS); i++)
      chk($sformatf("%s s%0d", name, i), 64'(frame_out[i*SW +: SW]), 64'(exp_s[i]));
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    flush = 1'b0;
    frame_ready = 1'b0;
    #1;
    chk({name, " fv"}, 64'(frame_valid), 64'd0);
    chk({name, " fill"}, 64'(fill_level), 64'd0);
    chk({name, " ovr"}, 64'(overrun), 64'd0);
    chk({name, " frame_nz"}, 64'(frame_out != '0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk({name, " rdy"}, 64'(sample_ready), 64'd1);
  endtask

  // Stream exp_s[] back-to-back; frame_valid must stay low until the last edge.
  task automatic stream_frame(input string name);
    for (int i = 0; i < int'(BS); i++) begin
      sample_valid = 1'b1;
      sample_in = exp_s[i];
      #1;
      chk($sformatf("%s rdy%0d", name, i), 64'(sample_ready), 64'd1);
      if (i == int'(BS) - 1) chk({name, " fv_early"}, 64'(frame_valid), 64'd0);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //          sv   s      fl   rdy  fill fv   ovr
    vecs[0] = '{1'b1, 32'd5, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd6, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'd7, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'd8, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'd9, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0};

    // Control table: flush/fill behaviour
    do_reset("tbl_rst");
    for (int v = 0; v < 7; v++) begin
      sample_valid = vecs[v].sv;
      sample_in = vecs[v].s;
      flush = vecs[v].fl;
      #1;
      chk($sformatf("tbl%0d rdy", v), 64'(sample_ready), 64'(vecs[v].e_rdy));
      tick();
      chk($sformatf("tbl%0d fill", v), 64'(fill_level), 64'(vecs[v].e_fill));
      chk($sformatf("tbl%0d fv", v), 64'(frame_valid), 64'(vecs[v].e_fv));
      chk($sformatf("tbl%0d ovr", v), 64'(overrun), 64'(vecs[v].e_ovr));
    end
    sample_valid = 1'b0;
    flush = 1'b0;

    // 1: sine frame, consumer always ready
    do_reset("t1_rst");
    frame_ready = 1'b1;
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'($rtoi($floor(1000.0 * $sin(real'(i)))));
    stream_frame("t1");
    chk("t1 fv", 64'(frame_valid), 64'd1);
    chk("t1 fill", 64'(fill_level), 64'd0);
    chk_frame("t1 frame");
    tick();
    chk("t1 fv_one_cycle", 64'(frame_valid), 64'd0);

    // 2: both banks full, overrun, back-to-back drain
    do_reset("t2_rst");
    for (int i = 0; i < 2 * int'(BS); i++) begin
      sample_valid = 1'b1;
      sample_in = 32'(i);
      tick();
    end
    #1;
    chk("t2 rdy_low", 64'(sample_ready), 64'd0);
    chk("t2 fill_full", 64'(fill_level), 64'd32);
    chk("t2 ovr_pre", 64'(overrun), 64'd0);
    sample_in = 32'd64;
    tick();
    sample_valid = 1'b0;
    chk("t2 ovr", 64'(overrun), 64'd1);
    chk("t2 fv0", 64'(frame_valid), 64'd1);
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'(i);
    chk_frame("t2 frameA");
    frame_ready = 1'b1;
    tick();
    chk("t2 fv1", 64'(frame_valid), 64'd1);
    chk("t2 rdy_back", 64'(sample_ready), 64'd1);
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'(i + 32);
    chk_frame("t2 frameB");
    tick();
    chk("t2 fv_drained", 64'(frame_valid), 64'd0);
    chk("t2 ovr_sticky", 64'(overrun), 64'd1);
    frame_ready = 1'b0;

    // 3: partial frame discarded by flush
    do_reset("t3_rst");
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_in = 32'(i + 1);
      tick();
    end
    chk("t3 fill10", 64'(fill_level), 64'd10);
    flush = 1'b1;
    sample_in = 32'd999;
    #1;
    chk("t3 rdy_flush", 64'(sample_ready), 64'd0);
    tick();
    flush = 1'b0;
    sample_valid = 1'b0;
    chk("t3 ovr", 64'(overrun), 64'd0);
    chk("t3 fill0", 64'(fill_level), 64'd0);
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'(100 + i);
    stream_frame("t3");
    chk("t3 fv", 64'(frame_valid), 64'd1);
    chk_frame("t3 frame");
    frame_ready = 1'b1;
    tick();
    chk("t3 single_frame", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;

    // 4: held frame stable while second bank fills
    do_reset("t4_rst");
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'(i * 7 - 50);
    stream_frame("t4");
    for (int c = 0; c < 20; c++) begin
      sample_valid = 1'b1;
      sample_in = 32'hA5A5_0000 + 32'(c);
      tick();
      chk($sformatf("t4 fv c%0d", c), 64'(frame_valid), 64'd1);
      chk($sformatf("t4 fill c%0d", c), 64'(fill_level), 64'(c + 1));
      chk($sformatf("t4 hold c%0d", c), 64'(frame_out != {exp_s[31], exp_s[30], exp_s[29], exp_s[28],
        exp_s[27], exp_s[26], exp_s[25], exp_s[24], exp_s[23], exp_s[22], exp_s[21], exp_s[20],
        exp_s[19], exp_s[18], exp_s[17], exp_s[16], exp_s[15], exp_s[14], exp_s[13], exp_s[12],
        exp_s[11], exp_s[10], exp_s[9], exp_s[8], exp_s[7], exp_s[6], exp_s[5], exp_s[4],
        exp_s[3], exp_s[2], exp_s[1], exp_s[0]}), 64'd0);
    end
    sample_valid = 1'b0;

    // 5: async reset with one full bank and 17 samples pending
    do_reset("t5_pre");
    for (int i = 0; i < int'(BS) + 17; i++) begin
      sample_valid = 1'b1;
      sample_in = 32'(i + 5000);
      tick();
    end
    sample_valid = 1'b0;
    chk("t5 fv_before", 64'(frame_valid), 64'd1);
    chk("t5 fill17", 64'(fill_level), 64'd17);
    do_reset("t5_rst");
    for (int i = 0; i < int'(BS); i++) exp_s[i] = 32'(200 + i);
    stream_frame("t5");
    chk("t5 fv", 64'(frame_valid), 64'd1);
    chk_frame("t5 frame");
    frame_ready = 1'b1;
    tick();
    chk("t5 single_frame", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;

    // 6: signed extremes packed verbatim
    do_reset("t6_rst");
    for (int i = 0; i < int'(BS); i++) exp_s[i] = (i % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    stream_frame("t6");
    chk("t6 fv", 64'(frame_valid), 64'd1);
    chk_frame("t6 frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
